// File: rtl/inst_encoder_loader.sv
// Re-encodes decoded RV32I field bundles into 32-bit instruction words, buffers them
// in a small FIFO and streams them into instruction memory at consecutive word addresses.
module inst_encoder_loader #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [3:0]       inst_type,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic [19:0]      immediate,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  input  logic             imem_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] word_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_nxt;

  logic [31:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic [31:0]    addr_p0;
  logic           fifo_empty, fifo_full;
  logic           accept, push, pop, start_ok;
  logic [32:0]    enc;
  logic           enc_ok;
  logic [31:0]    enc_word;

  // Bundle layout matches the decoder: the 20-bit immediate is packed from bit 0 upward.
  function automatic logic [32:0] encode_fields(
    input logic [3:0]  t,
    input logic [4:0]  f_rd,
    input logic [4:0]  f_rs1,
    input logic [4:0]  f_rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [19:0] imm
  );
    logic [32:0] r;
    r = '0;
    case (t)
      4'b0001: r = {1'b1, imm[11:0], f_rs1, f3, f_rd, 7'b0000011};
      4'b0010: r = {1'b1, imm[11:5], f_rs2, f_rs1, f3, imm[4:0], 7'b0100011};
      4'b0011: r = {1'b1, f7, f_rs2, f_rs1, f3, f_rd, 7'b0110011};
      4'b0100: r = {1'b1, imm[11:0], f_rs1, f3, f_rd, 7'b0010011};
      4'b0101: r = {1'b1, imm[11], imm[9:4], f_rs2, f_rs1, f3, imm[3:0], imm[10], 7'b1100011};
      4'b0110: r = {1'b1, imm[19], imm[9:0], imm[10], imm[18:11], f_rd, 7'b1101111};
      4'b0111: r = {1'b1, imm[11:0], f_rs1, 3'b000, f_rd, 7'b1100111};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign enc      = encode_fields(inst_type, rd, rs1, rs2, func3, func7, immediate);
  assign enc_ok   = enc[32];
  assign enc_word = enc[31:0];

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign in_ready  = (state == RUN) && !fifo_full;
  assign accept    = in_valid && in_ready;
  assign push      = accept && enc_ok;
  assign pop       = imem_we && imem_ready;
  assign start_ok  = (state == IDLE) && start;

  assign imem_we    = !fifo_empty;
  assign imem_addr  = addr_p0;
  assign imem_wdata = fifo_empty ? 32'h0 : fifo_mem[rd_ptr[PTR_W-1:0]];
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && in_last) state_nxt = DRAIN;
      DRAIN: begin
        if (fifo_empty) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: control state, pointers and the write address register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      addr_p0    <= 32'h0;
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        addr_p0 <= addr_p0 + 32'd4;
        if (word_count != {CNT_W{1'b1}}) word_count <= word_count + CNT_W'(1);
      end
      if (accept && !enc_ok) err <= 1'b1;
      if (start_ok) begin
        addr_p0    <= base_addr & 32'hFFFF_FFFC;
        err        <= 1'b0;
        word_count <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= enc_word;
  end

endmodule
